seg7_scan_driver: RTL and testbench

//   Downstream display stage for the clock counter: takes a packed BCD count and

---
 rtl/seg7_scan_driver.sv | 184 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Display stage for the clock counter. Takes a packed BCD count and drives a
//   multiplexed common-anode 7-segment display one digit at a time. A short
//   blanking gap between digits suppresses ghosting.
//
//   A new value is captured into a pending register on value_valid. It is copied
//   into the display register only when the digit index wraps from the last
//   digit back to 0, so a digit never changes in the middle of a frame.
//
//   Optional feature (compile-time macro SEG7_LEADING_ZERO_BLANK_EN):
//   a digit k (k>=1) is blanked when it and all higher digits are 0. Its anode
//   is still driven during its slot. Digit 0 is always shown.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   value        in   [4*NUM_DIGITS-1:0] BCD digits, digit 0 = value[3:0] (rightmost)
//   value_valid  in   1-cycle strobe that captures value into the pending register
//   seg          out  [6:0] segments {g,f,e,d,c,b,a}
//   an           out  [NUM_DIGITS-1:0] one-hot digit enables, an[0] = digit 0
//   frame_done   out  1-cycle pulse after the last digit's slot ends
//
// Handshake: value/value_valid are synchronous to clk. There is no back-pressure:
//   every cycle with value_valid=1 overwrites pending, so the last strobe wins.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int DIGIT_CYCLES   = 12000,
   parameter int BLANK_CYCLES   = 120,
   parameter int TIMER_WIDTH    = 14,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic                      value_valid,
   output logic [6:0]                seg,
   output logic [NUM_DIGITS-1:0]     an,
   output logic                      frame_done
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [TIMER_WIDTH-1:0] DRIVE_LAST = TIMER_WIDTH'(DIGIT_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] BLANK_LAST =
      TIMER_WIDTH'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   // Inactive output levels: all ones for active-low drive, all zeros otherwise.
   localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   // With no blanking gap the scan lives entirely in DRIVE.
   localparam state_t ST_RESET = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;

   state_t                    state, state_n;
   logic [TIMER_WIDTH-1:0]    timer, timer_n;
   logic [IDX_W-1:0]          idx, idx_n;
   logic [4*NUM_DIGITS-1:0]   pending;
   logic [4*NUM_DIGITS-1:0]   display, display_n;
   logic                      wrap;
   logic [3:0]                digit;
   logic [6:0]                seg_hi;
   logic [NUM_DIGITS-1:0]     an_hi;
   logic                      lz_blank;
   logic [6:0]                seg_n;
   logic [NUM_DIGITS-1:0]     an_n;

   // Active-high gfedcba decode; non-BCD codes show a dash.
   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   // Next-state logic. Outputs are computed for the state being entered so
   // that the registered seg/an change on the same edge as the state.
   always_comb begin
      state_n   = state;
      timer_n   = timer + 1'b1;
      idx_n     = idx;
      wrap      = 1'b0;
      seg_n     = SEG_OFF;
      an_n      = AN_OFF;
      lz_blank  = 1'b0;

      case (state)
         ST_BLANK: begin
            if (timer == BLANK_LAST) begin
               state_n = ST_DRIVE;
               timer_n = '0;
            end
         end
         ST_DRIVE: begin
            if (timer == DRIVE_LAST) begin
               timer_n = '0;
               state_n = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
               if (idx == IDX_LAST) begin
                  idx_n = '0;
                  wrap  = 1'b1;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         default: begin
            state_n = ST_RESET;
            timer_n = '0;
         end
      endcase

      // Frame load happens on the wrap edge; the first digit of the new frame
      // must already be decoded from the newly loaded value.
      display_n = wrap ? pending : display;
      digit     = display_n[4*idx_n +: 4];
      seg_hi    = decode(digit);
      an_hi     = NUM_DIGITS'(1) << idx_n;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
      // Blank when this digit and every higher digit are zero (never digit 0).
      lz_blank = (idx_n != '0);
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if ((k >= int'(idx_n)) && (display_n[4*k +: 4] != 4'd0)) begin
            lz_blank = 1'b0;
         end
      end
`else
      lz_blank = 1'b0;
`endif

      if (lz_blank) begin
         seg_hi = 7'h00;
      end

      if (state_n == ST_DRIVE) begin
         seg_n = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
         an_n  = (SEG_ACTIVE_LOW != 0) ? ~an_hi  : an_hi;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_RESET;
         timer      <= '0;
         idx        <= '0;
         pending    <= '0;
         display    <= '0;
         seg        <= SEG_OFF;
         an         <= AN_OFF;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         idx        <= idx_n;
         display    <= display_n;
         seg        <= seg_n;
         an         <= an_n;
         frame_done <= wrap;
         // A strobe on the wrap edge lands in pending only (shown next frame).
         if (value_valid) begin
            pending <= value;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

   localparam int ND = 2;
   localparam int NCYC = 61;

   logic          clk;
   logic          rst;
   logic [7:0]    value;
   logic          value_valid;
   logic [6:0]    seg;
   logic [1:0]    an;
   logic          frame_done;

   int checks;
   int errors;

   seg7_scan_driver #(
      .NUM_DIGITS     (ND),
      .DIGIT_CYCLES   (4),
      .BLANK_CYCLES   (1),
      .TIMER_WIDTH    (3),
      .SEG_ACTIVE_LOW (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .value       (value),
      .value_valid (value_valid),
      .seg         (seg),
      .an          (an),
      .frame_done  (frame_done)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [7:0] value;
      logic [1:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_fd;
   } vec_t;

   vec_t vec [NCYC];

   // Active-low segment code of a digit 1 with leading zeros: blank with the
   // leading-zero feature, otherwise decoded "0".
`ifdef SEG7_LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'h40;
`endif

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // Expected outputs for one 10-cycle frame starting at cycle 10*k:
   // blank (with frame_done after the first frame), digit 0 x4, blank, digit 1 x4.
   task automatic set_frame(input int k, input logic [6:0] s0, input logic [6:0] s1);
      int b;
      b = 10 * k;
      vec[b] = '{1'b0, 8'h00, 2'b11, 7'h7F, (k > 0)};
      for (int i = 1; i <= 4; i++) vec[b+i] = '{1'b0, 8'h00, 2'b10, s0, 1'b0};
      vec[b+5] = '{1'b0, 8'h00, 2'b11, 7'h7F, 1'b0};
      for (int i = 6; i <= 9; i++) vec[b+i] = '{1'b0, 8'h00, 2'b01, s1, 1'b0};
   endtask

   task automatic strobe(input int c, input logic [7:0] v);
      vec[c].valid = 1'b1;
      vec[c].value = v;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      value = 8'h00;
      value_valid = 1'b0;

      // Table: frames 0..5, hand-decoded active-low segment codes.
      set_frame(0, 7'h40, LZ);      // display 00 after reset
      set_frame(1, 7'h10, 7'h30);   // 39
      set_frame(2, 7'h24, 7'h79);   // 12 (strobed during frame 1 digit 0)
      set_frame(3, 7'h3F, LZ);      // 0A: dash, then leading "0"
      set_frame(4, 7'h3F, LZ);      // 0A still: 05 strobed on the wrap edge
      set_frame(5, 7'h12, LZ);      // 05
      vec[60] = '{1'b0, 8'h00, 2'b11, 7'h7F, 1'b1};
      strobe(2,  8'h39);
      strobe(12, 8'h12);
      strobe(22, 8'h77);            // overwritten by the next strobe
      strobe(27, 8'h0A);
      strobe(39, 8'h05);            // same edge as frame load

      // Pre-run: load 77 into the display so reset clearing it is visible.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_hold_seg", {1'b0, seg}, 8'h7F);
      check("reset_hold_an", {6'b0, an}, 8'h03);
      rst = 1'b0;
      value = 8'h77;
      value_valid = 1'b1;
      tick();
      value_valid = 1'b0;
      repeat (13) tick();          // cycle 14: frame 1, digit 0 slot
      check("pre_drive_an", {6'b0, an}, 8'h02);
      check("pre_drive_seg", {1'b0, seg}, 8'h78);

      // Asynchronous reset mid-DRIVE: outputs must drop with no clock edge.
      #2 rst = 1'b1;
      #1;
      check("async_rst_seg", {1'b0, seg}, 8'h7F);
      check("async_rst_an", {6'b0, an}, 8'h03);
      check("async_rst_fd", {7'b0, frame_done}, 8'h00);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Table run: sample cycle c outputs, drive cycle c inputs, advance.
      for (int c = 0; c < NCYC; c++) begin
         check($sformatf("c%0d_an", c), {6'b0, an}, {6'b0, vec[c].exp_an});
         check($sformatf("c%0d_seg", c), {1'b0, seg}, {1'b0, vec[c].exp_seg});
         check($sformatf("c%0d_fd", c), {7'b0, frame_done}, {7'b0, vec[c].exp_fd});
         value_valid = vec[c].valid;
         value = vec[c].value;
         tick();
      end
      value_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
